// File: rtl/ysyx_lsu_mem_responder_pkg.sv
// rtl/ysyx_lsu_mem_responder_pkg.sv - shared FSM states, size strobes and lane helpers
package ysyx_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_GAP     = 3'd5
    } mem_state_t;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0f;

    // Unknown strobe codes fall back to a full word.
    function automatic logic [3:0] size_mask(input logic [7:0] strb);
        case (strb)
            STRB_B:  return 4'b0001;
            STRB_H:  return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Lanes pushed past byte 3 fall off the top of the word.
    function automatic logic [3:0] lane_en(input logic [7:0] strb, input logic [1:0] off);
        return size_mask(strb) << off;
    endfunction

endpackage

// File: rtl/ysyx_lsu_mem_responder_if.sv
// rtl/ysyx_lsu_mem_responder_if.sv - LSU load/store request and response bundle
interface ysyx_lsu_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] lsu_araddr;
    logic              lsu_arvalid;
    logic [7:0]        lsu_rstrb;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_rvalid;
    logic [ADDR_W-1:0] lsu_awaddr;
    logic              lsu_awvalid;
    logic [DATA_W-1:0] lsu_wdata;
    logic [7:0]        lsu_wstrb;
    logic              lsu_wvalid;
    logic              lsu_wready;

    modport master (
        output lsu_araddr, lsu_arvalid, lsu_rstrb,
        output lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
        input  lsu_rdata, lsu_rvalid, lsu_wready
    );

    modport slave (
        input  lsu_araddr, lsu_arvalid, lsu_rstrb,
        input  lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
        output lsu_rdata, lsu_rvalid, lsu_wready
    );
endinterface

// File: rtl/ysyx_lsu_mem_responder_sram_bank.sv
// rtl/ysyx_lsu_mem_responder_sram_bank.sv - word SRAM, byte-enable sync write, async read
module ysyx_mem_sram_bank #(
    parameter  int MEM_WORDS = 1024,
    parameter  int DATA_W    = 32,
    localparam int IDX_W     = $clog2(MEM_WORDS),
    localparam int NB        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [NB-1:0]     be,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ysyx_lsu_mem_responder.sv
// rtl/ysyx_lsu_mem_responder.sv - LSU memory responder FSM; YSYX_LSU_MEM_ADDR_CHECK_EN adds range/alignment errors
module ysyx_lsu_mem_responder
    import ysyx_mem_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h8000_0000,
    parameter int              LATENCY   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ysyx_lsu_mem_responder_if.slave bus,
    output logic                    err_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam int NB    = DATA_W / 8;

    mem_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        strb_q;
    logic              fault_q;
    logic              rvalid_q;
    logic              wready_q;
    logic [DATA_W-1:0] rdata_q;

    logic              store_sel;
    logic              start;
    logic [ADDR_W-1:0] cap_addr;
    logic [7:0]        cap_strb;
    logic              cap_fault;

    assign store_sel = bus.lsu_awvalid && bus.lsu_wvalid;
    assign start     = (state_q == ST_IDLE) && (store_sel || bus.lsu_arvalid);
    assign cap_addr  = store_sel ? bus.lsu_awaddr : bus.lsu_araddr;
    assign cap_strb  = store_sel ? bus.lsu_wstrb  : bus.lsu_rstrb;

`ifdef YSYX_LSU_MEM_ADDR_CHECK_EN
    logic [ADDR_W-1:0] cap_off;
    logic              err_q;

    assign cap_off   = cap_addr - ADDR_BASE;
    assign cap_fault = (cap_off >= ADDR_W'(4 * MEM_WORDS))
                    || ((cap_strb == STRB_H) && cap_addr[0])
                    || ((cap_strb == STRB_W) && (cap_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start && cap_fault) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign cap_fault = 1'b0;
    assign err_o     = 1'b0;
`endif

    // Word index wraps inside the bank; the low two bits pick the byte lane.
    logic [IDX_W-1:0]  idx;
    logic [1:0]        off;
    logic [DATA_W-1:0] sram_rdata;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_data;
    logic [3:0]        rd_mask;
    logic              sram_we;

    assign idx      = IDX_W'((addr_q - ADDR_BASE) >> 2);
    assign off      = addr_q[1:0];
    assign rd_shift = sram_rdata >> {off, 3'b000};
    assign rd_mask  = size_mask(strb_q);
    assign sram_we  = (state_q == ST_WR_RESP) && !fault_q;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (rd_mask[i]) begin
                rd_data[8*i +: 8] = rd_shift[8*i +: 8];
            end
        end
    end

    ysyx_mem_sram_bank #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_W    (DATA_W)
    ) u_bank (
        .clk   (clk),
        .we    (sram_we),
        .be    (lane_en(strb_q, off)),
        .addr  (idx),
        .wdata (wdata_q << {off, 3'b000}),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            fault_q  <= 1'b0;
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= cap_addr;
                        strb_q  <= cap_strb;
                        wdata_q <= bus.lsu_wdata;
                        fault_q <= cap_fault;
                        cnt_q   <= CNT_W'(LATENCY);
                        state_q <= store_sel ? ST_WR_WAIT : ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q  <= ST_RD_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= fault_q ? '0 : rd_data;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_WR_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q  <= ST_WR_RESP;
                        wready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                // The bank write lands on the edge that leaves WR_RESP.
                ST_RD_RESP, ST_WR_RESP: state_q <= ST_GAP;
                ST_GAP:                 state_q <= ST_IDLE;
                default:                state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.lsu_rvalid = rvalid_q;
    assign bus.lsu_wready = wready_q;
    assign bus.lsu_rdata  = rdata_q;

endmodule

// File: tb/tb_ysyx_lsu_mem_responder.sv
// tb/tb_ysyx_lsu_mem_responder.sv - scoreboard bench with byte-level memory model
module tb_ysyx_lsu_mem_responder;
    import ysyx_mem_pkg::*;

    localparam int          LAT       = 2;
    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] BASE      = 32'h8000_0000;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          exact;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_o;
    always #5 clk = ~clk;

    ysyx_lsu_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus();

    ysyx_lsu_mem_responder #(
        .ADDR_W(32), .DATA_W(32), .MEM_WORDS(MEM_WORDS), .ADDR_BASE(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .err_o(err_o)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        rd_q[$];
    exp_t        wr_q[$];
    exp_t        me;
    logic [31:0] mem_m [MEM_WORDS];
    bit          err_m = 1'b0;
    bit          prev_rv = 1'b0;
    bit          prev_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [7:0] s);
        case (s)
            STRB_B:  return 1;
            STRB_H:  return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return int'((d >> 2) % MEM_WORDS);
    endfunction

    function automatic bit faulty(input logic [31:0] a, input logic [7:0] s);
        logic [31:0] d;
        d = a - BASE;
`ifdef YSYX_LSU_MEM_ADDR_CHECK_EN
        if (d >= 4 * MEM_WORDS) return 1'b1;
        if (s == STRB_H && a[0]) return 1'b1;
        if (s == STRB_W && a[1:0] != 2'b00) return 1'b1;
`endif
        return (d > 32'hffff_ffff) && (s == 8'hff);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [7:0] s);
        logic [31:0] w, r;
        int lane;
        if (faulty(a, s)) begin
            err_m = 1'b1;
            return 32'h0;
        end
        w = mem_m[widx(a)];
        r = 32'h0;
        for (int b = 0; b < nbytes(s); b++) begin
            lane = int'(a[1:0]) + b;
            if (lane < 4) r[8*b +: 8] = w[8*lane +: 8];
        end
        return r;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [7:0] s, input logic [31:0] wd);
        int lane, i;
        if (faulty(a, s)) begin
            err_m = 1'b1;
            return;
        end
        i = widx(a);
        for (int b = 0; b < nbytes(s); b++) begin
            lane = int'(a[1:0]) + b;
            if (lane < 4) mem_m[i][8*lane +: 8] = wd[8*b +: 8];
        end
    endfunction

    task automatic wait_pulse(input bit is_rd);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (is_rd ? bus.lsu_rvalid : bus.lsu_wready) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no pulse in 60 cycles, expected one", is_rd ? "rvalid" : "wready");
    endtask

    task automatic push_exp(input bit is_rd, input logic [31:0] d, input int c, input bit exact);
        exp_t e;
        e.data = d; e.cyc = c; e.exact = exact;
        if (is_rd) rd_q.push_back(e); else wr_q.push_back(e);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic issue_load(input logic [31:0] a, input logic [7:0] s);
        push_exp(1'b1, model_load(a, s), cyc + 2 + LAT, 1'b1);
        bus.lsu_araddr = a; bus.lsu_rstrb = s; bus.lsu_arvalid = 1'b1;
        wait_pulse(1'b1);
        bus.lsu_arvalid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic issue_store(input logic [31:0] a, input logic [7:0] s, input logic [31:0] wd);
        model_store(a, s, wd);
        push_exp(1'b0, 32'h0, cyc + 2 + LAT, 1'b1);
        bus.lsu_awaddr = a; bus.lsu_wstrb = s; bus.lsu_wdata = wd;
        bus.lsu_awvalid = 1'b1; bus.lsu_wvalid = 1'b1;
        wait_pulse(1'b0);
        bus.lsu_awvalid = 1'b0; bus.lsu_wvalid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 1'b0;
            prev_wr = 1'b0;
        end else begin
            if (bus.lsu_rvalid) begin
                chk("rvalid_width", {31'b0, prev_rv}, 32'h0);
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rvalid_unexpected: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    me = rd_q.pop_front();
                    chk("rdata", bus.lsu_rdata, me.data);
                    if (me.exact) chk("rd_latency", cyc, me.cyc);
                    else chk("rd_latency_min", {31'b0, cyc >= me.cyc}, 32'h1);
                end
            end
            if (bus.lsu_wready) begin
                chk("wready_width", {31'b0, prev_wr}, 32'h0);
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wready_unexpected: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    me = wr_q.pop_front();
                    if (me.exact) chk("wr_latency", cyc, me.cyc);
                    else chk("wr_latency_min", {31'b0, cyc >= me.cyc}, 32'h1);
                end
            end
            prev_rv = bus.lsu_rvalid;
            prev_wr = bus.lsu_wready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d;
        logic [7:0]  s;
        int          c;
        bus.lsu_araddr = '0; bus.lsu_arvalid = 1'b0; bus.lsu_rstrb = '0;
        bus.lsu_awaddr = '0; bus.lsu_awvalid = 1'b0; bus.lsu_wdata = '0;
        bus.lsu_wstrb = '0; bus.lsu_wvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rvalid", {31'b0, bus.lsu_rvalid}, 32'h0);
        chk("reset_wready", {31'b0, bus.lsu_wready}, 32'h0);
        chk("reset_rdata", bus.lsu_rdata, 32'h0);
        chk("reset_err", {31'b0, err_o}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 16; w++) issue_store(BASE + 32'(4 * w), STRB_W, $urandom);

        issue_store(32'h8000_0010, STRB_W, 32'hDEAD_BEEF);
        issue_load(32'h8000_0010, STRB_W);
        issue_store(32'h8000_0013, STRB_B, 32'h0000_005A);
        issue_load(32'h8000_0010, STRB_W);
        issue_load(32'h8000_0013, STRB_B);
        issue_load(32'h8000_0012, STRB_H);

        for (int n = 0; n < 60; n++) begin
            a = BASE + 32'(4 * ($urandom % 16)) + 32'($urandom % 4);
            if ($urandom % 5 == 0) a = a + 32'(4 * MEM_WORDS);
            case ($urandom % 3)
                0: s = STRB_B;
                1: s = STRB_H;
                default: s = STRB_W;
            endcase
            if ($urandom % 2 == 0) issue_store(a, s, $urandom);
            else issue_load(a, s);
        end

        // Level-held load is served twice, separated by the GAP cycle.
        a = 32'h8000_0024;
        d = model_load(a, STRB_W);
        push_exp(1'b1, d, cyc + 2 + LAT, 1'b1);
        push_exp(1'b1, d, cyc + 2 + LAT + 3 + LAT, 1'b0);
        bus.lsu_araddr = a; bus.lsu_rstrb = STRB_W; bus.lsu_arvalid = 1'b1;
        wait_pulse(1'b1);
        wait_pulse(1'b1);
        bus.lsu_arvalid = 1'b0;
        repeat (2) @(negedge clk);

        // Store and load raised together: store first, load sees new data.
        a = 32'h8000_0028;
        d = $urandom;
        c = cyc;
        model_store(a, STRB_W, d);
        push_exp(1'b0, 32'h0, c + 2 + LAT, 1'b1);
        push_exp(1'b1, model_load(a, STRB_W), c + 3 + LAT, 1'b0);
        bus.lsu_awaddr = a; bus.lsu_wstrb = STRB_W; bus.lsu_wdata = d;
        bus.lsu_araddr = a; bus.lsu_rstrb = STRB_W;
        bus.lsu_awvalid = 1'b1; bus.lsu_wvalid = 1'b1; bus.lsu_arvalid = 1'b1;
        wait_pulse(1'b0);
        bus.lsu_awvalid = 1'b0; bus.lsu_wvalid = 1'b0;
        wait_pulse(1'b1);
        bus.lsu_arvalid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during a load wait: no pulse, outputs cleared asynchronously.
        issue_load(32'h8000_0010, STRB_W);
        bus.lsu_araddr = 32'h8000_0020; bus.lsu_rstrb = STRB_W; bus.lsu_arvalid = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rvalid", {31'b0, bus.lsu_rvalid}, 32'h0);
        chk("abort_rdata", bus.lsu_rdata, 32'h0);
        chk("abort_wready", {31'b0, bus.lsu_wready}, 32'h0);
        bus.lsu_arvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        err_m = 1'b0;

        // Reset during a store wait: the word keeps its old value.
        a = 32'h8000_001C;
        bus.lsu_awaddr = a; bus.lsu_wstrb = STRB_W; bus.lsu_wdata = ~mem_m[7];
        bus.lsu_awvalid = 1'b1; bus.lsu_wvalid = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        bus.lsu_awvalid = 1'b0; bus.lsu_wvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue_load(a, STRB_W);

        issue_load(32'h7FFF_FFFC, STRB_W);
        chk("err_after_oob", {31'b0, err_o}, {31'b0, err_m});
        issue_store(32'h8000_0001, STRB_H, 32'h0000_1234);
        issue_load(32'h8000_0000, STRB_W);
        issue_load(32'h8000_0010, STRB_W);

        repeat (10) @(negedge clk);
        chk("rd_queue_empty", rd_q.size(), 32'h0);
        chk("wr_queue_empty", wr_q.size(), 32'h0);
        chk("err_final", {31'b0, err_o}, {31'b0, err_m});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
